// File: rtl/adel_pkg.sv
// Shared types and instruction-format helpers for the ADEL core.
package adel_pkg;

    localparam int unsigned OPC_W = 3;

    // Control state of the core.
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MEM  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Opcodes with w=1 (result written to rf[dst]).
    typedef enum logic [OPC_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_LD  = 3'd7
    } wop_t;

    // Opcodes with w=0 (control flow, store, nop, halt).
    typedef enum logic [OPC_W-1:0] {
        OP_BEQZ = 3'd0,
        OP_BLTZ = 3'd1,
        OP_BGTZ = 3'd2,
        OP_BNEZ = 3'd3,
        OP_ST   = 3'd4,
        OP_JMP  = 3'd5,
        OP_NOP  = 3'd6,
        OP_HALT = 3'd7
    } cop_t;

    // Total instruction width: w + opc + rs + dst + src1 + imm.
    function automatic int unsigned inst_width(input int unsigned rw, input int unsigned imm_w);
        return 5 + 2 * rw + imm_w;
    endfunction

    // LSB of the src1 field (directly above imm).
    function automatic int unsigned fld_src1_lsb(input int unsigned imm_w);
        return imm_w;
    endfunction

    // LSB of the dst field.
    function automatic int unsigned fld_dst_lsb(input int unsigned rw, input int unsigned imm_w);
        return imm_w + rw;
    endfunction

    // Position of the rs (register operand B) bit.
    function automatic int unsigned fld_rs_bit(input int unsigned rw, input int unsigned imm_w);
        return imm_w + 2 * rw;
    endfunction

    // LSB of the opcode field.
    function automatic int unsigned fld_opc_lsb(input int unsigned rw, input int unsigned imm_w);
        return imm_w + 2 * rw + 1;
    endfunction

    // Position of the w (write-back group) bit, the instruction MSB.
    function automatic int unsigned fld_w_bit(input int unsigned rw, input int unsigned imm_w);
        return imm_w + 2 * rw + 4;
    endfunction

    // Sign-extend the low w bits of v to 64 bits (1 <= w <= 63); callers truncate.
    function automatic logic [63:0] sext64(input logic [63:0] v, input int unsigned w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return v[6'(w - 1)] ? (v | ~mask) : (v & mask);
    endfunction

endpackage

// File: rtl/adel_alu.sv
// Combinational ALU for the w=1 arithmetic/logic/shift opcodes.
module adel_alu
    import adel_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [OPC_W-1:0]  i_opc,
    output logic [DATA_W-1:0] o_result_c
);

    localparam int unsigned SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [SH_W-1:0] w_sh;

    assign w_sh = i_b[SH_W-1:0];

    // Result select; load opcode is handled by the core and yields zero here.
    always_comb begin
        o_result_c = '0;
        case (wop_t'(i_opc))
            OP_ADD:  o_result_c = i_a + i_b;
            OP_SUB:  o_result_c = i_a - i_b;
            OP_AND:  o_result_c = i_a & i_b;
            OP_OR:   o_result_c = i_a | i_b;
            OP_XOR:  o_result_c = i_a ^ i_b;
            OP_SHL:  o_result_c = i_a << w_sh;
            OP_SHR:  o_result_c = DATA_W'($signed(i_a) >>> w_sh);
            default: o_result_c = '0;
        endcase
    end

endmodule

// File: rtl/adel_core.sv
// ADEL single-issue in-order core: register file, pc, FSM and data-memory port.
module adel_core
    import adel_pkg::*;
#(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned NREG   = 4,
    parameter  int unsigned PC_W   = 8,
    parameter  int unsigned IMM_W  = 8,
    localparam int unsigned RW     = $clog2(NREG),
    localparam int unsigned INST_W = inst_width(RW, IMM_W)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [INST_W-1:0] inst,
    input  logic              inst_valid,
    output logic [PC_W-1:0]   pc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              retire,
    output logic              halted
);

    localparam int unsigned F_SRC1 = fld_src1_lsb(IMM_W);
    localparam int unsigned F_DST  = fld_dst_lsb(RW, IMM_W);
    localparam int unsigned F_RS   = fld_rs_bit(RW, IMM_W);
    localparam int unsigned F_OPC  = fld_opc_lsb(RW, IMM_W);
    localparam int unsigned F_W    = fld_w_bit(RW, IMM_W);

    // Architectural and interface state.
    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic [DATA_W-1:0] r_rf [NREG];
    logic              r_mem_req;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [RW-1:0]     r_ld_dst;
    logic              r_retire;
    logic              r_halted;

    // Decoded instruction fields.
    logic              w_wbit;
    logic [OPC_W-1:0]  w_opc;
    logic              w_rs;
    logic [RW-1:0]     w_dst;
    logic [RW-1:0]     w_src1;
    logic [RW-1:0]     w_src2;
    logic [IMM_W-1:0]  w_imm;
    logic [DATA_W-1:0] w_imm_d;
    logic [PC_W-1:0]   w_imm_pc;

    // Operands and derived values.
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_addr;
    logic [DATA_W-1:0] w_sdata;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_is_mem;
    logic              w_is_halt;
    logic              w_taken;

    assign w_wbit   = inst[F_W];
    assign w_opc    = inst[F_OPC +: OPC_W];
    assign w_rs     = inst[F_RS];
    assign w_dst    = inst[F_DST +: RW];
    assign w_src1   = inst[F_SRC1 +: RW];
    assign w_imm    = inst[IMM_W-1:0];
    assign w_src2   = w_imm[RW-1:0];

    assign w_imm_d  = DATA_W'(sext64(64'(w_imm), IMM_W));
    assign w_imm_pc = PC_W'(sext64(64'(w_imm), IMM_W));

    assign w_a      = r_rf[w_src1];
    assign w_b      = w_rs ? r_rf[w_src2] : w_imm_d;
    assign w_addr   = w_a + w_imm_d;
    assign w_sdata  = r_rf[w_dst];

    assign w_is_mem  = w_wbit ? (wop_t'(w_opc) == OP_LD) : (cop_t'(w_opc) == OP_ST);
    assign w_is_halt = !w_wbit && (cop_t'(w_opc) == OP_HALT);

    // Branch/jump decision on signed rf[src1] versus zero; only w=0 opcodes can branch.
    always_comb begin
        w_taken = 1'b0;
        if (!w_wbit) begin
            case (cop_t'(w_opc))
                OP_BEQZ: w_taken = (w_a == '0);
                OP_BLTZ: w_taken = w_a[DATA_W-1];
                OP_BGTZ: w_taken = !w_a[DATA_W-1] && (w_a != '0);
                OP_BNEZ: w_taken = (w_a != '0);
                OP_JMP:  w_taken = 1'b1;
                default: w_taken = 1'b0;
            endcase
        end
    end

    adel_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_a        (w_a),
        .i_b        (w_b),
        .i_opc      (w_opc),
        .o_result_c (w_alu_res)
    );

    // Core FSM: execute in RUN, wait for the memory handshake in MEM, freeze in HALT.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= ST_RUN;
            r_pc        <= '0;
            for (int unsigned i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ld_dst    <= '0;
            r_retire    <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (inst_valid) begin
                        if (w_is_mem) begin
                            // Launch the access; pc advances only on completion.
                            r_state     <= ST_MEM;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= !w_wbit;
                            r_mem_addr  <= w_addr;
                            r_mem_wdata <= w_sdata;
                            r_ld_dst    <= w_dst;
                        end else if (w_is_halt) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                            r_retire <= 1'b1;
                        end else begin
                            if (w_wbit) begin
                                r_rf[w_dst] <= w_alu_res;
                            end
                            r_pc     <= w_taken ? (r_pc + w_imm_pc) : (r_pc + PC_W'(1));
                            r_retire <= 1'b1;
                        end
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        if (!r_mem_we) begin
                            r_rf[r_ld_dst] <= mem_rdata;
                        end
                        r_pc      <= r_pc + PC_W'(1);
                        r_mem_req <= 1'b0;
                        r_state   <= ST_RUN;
                        r_retire  <= 1'b1;
                    end
                end
                ST_HALT: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign pc        = r_pc;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign retire    = r_retire;
    assign halted    = r_halted;

endmodule
